timer_prog: RTL and testbench

Programmable one-shot/periodic delay timer: the parametrised successor to the fixed microsecond and millisecond delay timers. A single instance counts delays in raw clock cycles, microseconds or milliseconds, selected per start. It runs one-shot or auto-reloading periodic, and can be aborted or restarted at any time. It sits beside the controller FSMs that need timed waits (power sequencing, bus turnaround, watchdog-style polling) and replaces per-unit timer instances.

---
 rtl/timer_prog_if.sv | 24 ++
 rtl/timer_prog.sv | 112 +++++++++++
 tb/tb_timer_prog.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/timer_prog_if.sv
// Control/status bundle for timer_prog: start/stop pulses and latched-on-start
// parameters in, busy/done/elapsed status out.
interface timer_prog_if #(
    parameter int BIT_LEN = 16
);
    logic               start;
    logic               stop;
    logic [1:0]         unit;
    logic               periodic;
    logic [BIT_LEN-1:0] delay;
    logic               busy;
    logic               done;
    logic [BIT_LEN-1:0] elapsed;

    modport master (
        output start, stop, unit, periodic, delay,
        input  busy, done, elapsed
    );

    modport slave (
        input  start, stop, unit, periodic, delay,
        output busy, done, elapsed
    );
endinterface

// File: rtl/timer_prog.sv
// Programmable one-shot/periodic delay timer. Delay is D units of T cycles,
// T selected per start (cycles / microseconds / milliseconds).
// Priority per edge: stop > start > terminal count.
module timer_prog #(
    parameter int CLK_PER_US = 125,
    parameter int BIT_LEN    = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    timer_prog_if.slave  bus
);
    localparam int PW = $clog2(1000 * CLK_PER_US);
    localparam logic [PW-1:0] T_US_MAX = PW'(CLK_PER_US - 1);
    localparam logic [PW-1:0] T_MS_MAX = PW'(1000 * CLK_PER_US - 1);

    typedef enum logic { IDLE, RUN } state_t;

    state_t             state, state_n;
    logic [BIT_LEN-1:0] d_q, d_n;
    logic [1:0]         tsel_q, tsel_n;
    logic               per_q, per_n;
    logic [PW-1:0]      presc, presc_n;
    logic [BIT_LEN-1:0] elap, elap_n;
    logic               busy_q, done_q, done_n;

    logic [PW-1:0]      tmax;
    logic               tick;
    logic               term;

    // Prescaler terminal value for the latched time base (11 aliases 10)
    always_comb begin
        tmax = '0;
        case (tsel_q)
            2'b00:   tmax = '0;
            2'b01:   tmax = T_US_MAX;
            default: tmax = T_MS_MAX;
        endcase
    end

    assign tick = (state == RUN) && (presc == tmax);
    // Compare against D-1 so elapsed never needs to hold D itself
    assign term = tick && (elap == d_q - BIT_LEN'(1));

    // Next-state and next-counter logic, stop > start > terminal count
    always_comb begin
        state_n = state;
        d_n     = d_q;
        tsel_n  = tsel_q;
        per_n   = per_q;
        presc_n = presc;
        elap_n  = elap;
        done_n  = 1'b0;
        if (bus.stop) begin
            state_n = IDLE;
            presc_n = '0;
            elap_n  = '0;
        end else if (bus.start) begin
            d_n     = bus.delay;
            tsel_n  = bus.unit;
            per_n   = bus.periodic;
            presc_n = '0;
            elap_n  = '0;
            if (bus.delay == '0) begin
                // Zero delay: immediate done, never enters RUN
                state_n = IDLE;
                done_n  = 1'b1;
            end else begin
                state_n = RUN;
            end
        end else if (state == RUN) begin
            if (tick) begin
                presc_n = '0;
                if (term) begin
                    done_n = 1'b1;
                    elap_n = '0;
                    if (!per_q) state_n = IDLE;
                end else begin
                    elap_n = elap + BIT_LEN'(1);
                end
            end else begin
                presc_n = presc + PW'(1);
            end
        end
    end

    // State, latched parameters, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            d_q    <= '0;
            tsel_q <= '0;
            per_q  <= 1'b0;
            presc  <= '0;
            elap   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            d_q    <= d_n;
            tsel_q <= tsel_n;
            per_q  <= per_n;
            presc  <= presc_n;
            elap   <= elap_n;
            busy_q <= (state_n == RUN);
            done_q <= done_n;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.elapsed = elap;
endmodule

// File: tb/tb_timer_prog.sv
// Bench for timer_prog: directed scenarios plus random traffic. A driver
// issues one cycle of stimulus at each falling edge and pushes the expected
// post-edge outputs from a time-based reference model; a monitor pops and
// compares after every rising edge.
module tb_timer_prog;
    localparam int CPU = 4;
    localparam int BL  = 8;

    typedef struct {
        bit    busy;
        bit    done;
        int    el;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: time since the start edge plus the latched parameters
    bit     m_run = 0;
    longint m_n = 0;
    longint m_d = 0;
    longint m_t = 1;
    bit     m_per = 0;

    timer_prog_if #(.BIT_LEN(BL)) bus ();
    timer_prog #(.CLK_PER_US(CPU), .BIT_LEN(BL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic longint t_of(logic [1:0] u);
        if (u == 2'b00) return 1;
        if (u == 2'b01) return CPU;
        return 1000 * CPU;
    endfunction

    // One cycle of stimulus; the model predicts the outputs after the next rising edge
    task automatic step(bit st, bit sp, logic [1:0] u, bit p, int dl, string tag);
        exp_t e;
        longint per;
        longint m;
        @(negedge clk);
        bus.start = st; bus.stop = sp; bus.unit = u; bus.periodic = p; bus.delay = BL'(dl);
        e.busy = 0; e.done = 0; e.el = 0; e.tag = tag;
        if (sp) begin
            m_run = 0;
        end else if (st) begin
            if (dl == 0) begin
                m_run = 0;
                e.done = 1;
            end else begin
                m_run = 1; m_n = 0; m_d = dl; m_t = t_of(u); m_per = p;
                e.busy = 1;
            end
        end else if (m_run) begin
            m_n++;
            per = m_d * m_t;
            if (m_per) begin
                m = m_n % per;
                e.busy = 1; e.done = (m == 0); e.el = int'(m / m_t);
            end else if (m_n == per) begin
                m_run = 0; e.done = 1;
            end else begin
                e.busy = 1; e.el = int'(m_n / m_t);
            end
        end
        q.push_back(e);
    endtask

    // Idle cycle with junk on the parameter inputs, which must be ignored
    task automatic idle(int n, string tag);
        for (int i = 0; i < n; i++)
            step(0, 0, 2'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 255)), tag);
    endtask

    task automatic chk_zero(string tag);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.elapsed !== '0) begin
            n_bad++;
            $display("FAIL %s: busy/done/elapsed got %0b/%0b/%0d want 0/0/0",
                     tag, bus.busy, bus.done, bus.elapsed);
        end
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear before any edge
    task automatic do_reset(string tag);
        exp_t e;
        @(negedge clk);
        rst_n = 1'b0;
        bus.start = 0; bus.stop = 0;
        m_run = 0;
        #1 chk_zero(tag);
        e.busy = 0; e.done = 0; e.el = 0; e.tag = tag;
        q.push_back(e);
        @(negedge clk);
        q.push_back(e);
        @(negedge clk);
        rst_n = 1'b1;
        q.push_back(e);
    endtask

    // Monitor: every rising edge the DUT presents a fresh output sample
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (bus.busy !== e.busy || bus.done !== e.done || bus.elapsed !== BL'(e.el)) begin
                    n_bad++;
                    $display("FAIL %s: busy/done/elapsed got %0b/%0b/%0d want %0b/%0b/%0d @%0t",
                             e.tag, bus.busy, bus.done, bus.elapsed, e.busy, e.done, e.el, $time);
                end
            end
        end
    end

    initial begin
        bit st, sp, p;
        logic [1:0] u;
        int dl;
        bus.start = 0; bus.stop = 0; bus.unit = 0; bus.periodic = 0; bus.delay = '0;
        repeat (3) @(posedge clk);
        #2 chk_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // One-shot cycles D=5
        step(1, 0, 2'b00, 0, 5, "oneshot_cyc5");
        idle(8, "oneshot_cyc5");
        // Microseconds D=3 -> 12 cycles; milliseconds D=1 -> 4000 cycles
        step(1, 0, 2'b01, 0, 3, "oneshot_us3");
        idle(15, "oneshot_us3");
        step(1, 0, 2'b10, 0, 1, "oneshot_ms1");
        idle(4003, "oneshot_ms1");
        // Periodic D=4, stop at E0+10
        step(1, 0, 2'b00, 1, 4, "periodic4");
        idle(9, "periodic4");
        step(0, 1, 2'b00, 0, 0, "periodic4_stop");
        idle(4, "periodic4_after");
        // Zero delay, both modes
        step(1, 0, 2'b00, 0, 0, "zero_oneshot");
        idle(3, "zero_oneshot");
        step(1, 0, 2'b01, 1, 0, "zero_periodic");
        idle(3, "zero_periodic");
        // Restart at E0+3
        step(1, 0, 2'b00, 0, 6, "restart");
        idle(2, "restart");
        step(1, 0, 2'b00, 0, 6, "restart");
        idle(8, "restart");
        // Stop on the terminal-count edge
        step(1, 0, 2'b00, 0, 6, "stop_at_term");
        idle(5, "stop_at_term");
        step(0, 1, 2'b00, 0, 0, "stop_at_term");
        idle(3, "stop_at_term");
        // Start on the terminal-count edge
        step(1, 0, 2'b00, 1, 6, "start_at_term");
        idle(5, "start_at_term");
        step(1, 0, 2'b00, 0, 2, "start_at_term");
        idle(4, "start_at_term");
        // Start together with stop
        step(1, 1, 2'b00, 0, 6, "start_stop");
        idle(8, "start_stop");
        // Stop while idle
        step(0, 1, 2'b00, 0, 3, "stop_idle");
        idle(2, "stop_idle");
        // Reset in the middle of a D=8 run
        step(1, 0, 2'b00, 0, 8, "mid_reset");
        idle(2, "mid_reset");
        do_reset("mid_reset");
        idle(10, "after_reset");
        // Maximum delay, elapsed reaches 2^BL-2
        step(1, 0, 2'b00, 0, 255, "max_delay");
        idle(258, "max_delay");

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            st = ($urandom_range(0, 19) == 0);
            sp = ($urandom_range(0, 59) == 0);
            p  = 1'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                u  = 2'($urandom_range(2, 3));
                dl = int'($urandom_range(0, 1));
            end else begin
                u  = 2'($urandom_range(0, 1));
                dl = int'($urandom_range(0, 12));
            end
            if (!st && !sp) begin
                u  = 2'($urandom_range(0, 3));
                dl = int'($urandom_range(0, 255));
            end
            step(st, sp, u, p, dl, "random");
        end
        idle(5, "drain");

        repeat (3) @(posedge clk);
        #3;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: pending got %0d want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
